// File: rtl/mem_dreq_ctrl.sv
// MEM-stage data SRAM request controller: one outstanding load/store, flush-aware cancellation.
// Optional DREQ_RDATA_BUF_EN adds a DONE state that buffers load data until WB accepts.
module mem_dreq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ms_valid,
  input  logic        ms_mem_req,
  input  logic        ms_we,
  input  logic [1:0]  ms_size,
  input  logic [31:0] ms_addr,
  input  logic [31:0] ms_wdata,
  input  logic [3:0]  ms_wstrb,
  input  logic        ms_ex,
  input  logic        flush,
  input  logic        ws_allowin,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic [3:0]  data_sram_wstrb,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        mem_ready_go,
  output logic [31:0] mem_dram_rdata
);

`ifdef DREQ_RDATA_BUF_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CANCEL} state_t;
`endif

  state_t state_q, state_d;
  logic   issue;
  logic   req_c;
  logic   ready_c;

  assign issue = ms_valid & ms_mem_req & ~ms_ex & ~flush;

  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    ready_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_c = ms_valid & (~ms_mem_req | ms_ex);
        if (issue) begin
          req_c   = 1'b1;
          state_d = data_sram_addr_ok ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        req_c = 1'b1;
        if (data_sram_addr_ok) state_d = flush ? S_CANCEL : S_WAIT;
        else if (flush)        state_d = S_IDLE;
      end
      S_WAIT: begin
        if (data_sram_data_ok) begin
          if (flush) state_d = S_IDLE;
          else begin
`ifdef DREQ_RDATA_BUF_EN
            state_d = S_DONE;
`else
            ready_c = 1'b1;
            state_d = S_IDLE;
`endif
          end
        end else if (flush) begin
          state_d = S_CANCEL;
        end
      end
`ifdef DREQ_RDATA_BUF_EN
      S_DONE: begin
        ready_c = 1'b1;
        if (ws_allowin | flush) state_d = S_IDLE;
      end
`endif
      S_CANCEL: begin
        // response of a flushed instruction is swallowed here
        if (data_sram_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

`ifdef DREQ_RDATA_BUF_EN
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else if (state_q == S_WAIT && data_sram_data_ok && !flush) rdata_q <= data_sram_rdata;
  end

  assign mem_dram_rdata = rst ? '0 : rdata_q;
`else
  logic unused_ws_allowin;
  assign unused_ws_allowin = ws_allowin;
  assign mem_dram_rdata    = rst ? '0 : data_sram_rdata;
`endif

  assign data_sram_req   = req_c & ~rst;
  assign mem_ready_go    = ready_c & ~rst;
  assign data_sram_wr    = ms_we;
  assign data_sram_size  = ms_size;
  assign data_sram_addr  = ms_addr;
  assign data_sram_wdata = ms_wdata;
  assign data_sram_wstrb = ms_we ? ms_wstrb : '0;

endmodule

// File: tb/tb_mem_dreq_ctrl.sv
// Bench for mem_dreq_ctrl: directed scenarios then random traffic against a transaction-level model.
module tb_mem_dreq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ms_valid, ms_mem_req, ms_we, ms_ex, flush, ws_allowin;
  logic [1:0]  ms_size;
  logic [31:0] ms_addr, ms_wdata;
  logic [3:0]  ms_wstrb;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_ready_go;
  logic [31:0] mem_dram_rdata;

  int checks = 0;
  int failures = 0;

`ifdef DREQ_RDATA_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  // transaction-level model: request presented / response owed / response to drop / result held
  bit          m_apend, m_rpend, m_drop, m_held, m_held_ld, m_iss;
  logic [31:0] m_cap;

  always #5 clk = ~clk;

  mem_dreq_ctrl dut (
    .clk(clk), .rst(rst),
    .ms_valid(ms_valid), .ms_mem_req(ms_mem_req), .ms_we(ms_we), .ms_size(ms_size),
    .ms_addr(ms_addr), .ms_wdata(ms_wdata), .ms_wstrb(ms_wstrb), .ms_ex(ms_ex),
    .flush(flush), .ws_allowin(ws_allowin),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .mem_ready_go(mem_ready_go), .mem_dram_rdata(mem_dram_rdata)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; samples 3 units later, well before the next edge.
  task automatic sample();
    bit busy, ereq, erg;
    #3;
    busy  = m_apend || m_rpend || m_held;
    m_iss = !busy && ms_valid && ms_mem_req && !ms_ex && !flush;
    ereq  = !rst && (m_apend || m_iss);
    erg   = !rst && (m_held
                     || (!busy && ms_valid && (!ms_mem_req || ms_ex))
                     || (!BUF && m_rpend && !m_drop && data_sram_data_ok && !flush));
    chk1("req", data_sram_req, ereq);
    chk1("ready_go", mem_ready_go, erg);
    if (ereq) begin
      chk1("wr", data_sram_wr, ms_we);
      chk32("addr", data_sram_addr, ms_addr);
      chk32("size", 32'(data_sram_size), 32'(ms_size));
      chk32("wdata", data_sram_wdata, ms_wdata);
      chk32("wstrb", 32'(data_sram_wstrb), ms_we ? 32'(ms_wstrb) : 32'd0);
    end
    if (rst) chk32("rdata_rst", mem_dram_rdata, 32'd0);
    else if (BUF && m_held && m_held_ld) chk32("rdata_held", mem_dram_rdata, m_cap);
    else if (!BUF && erg && m_rpend && !ms_we) chk32("rdata_pass", mem_dram_rdata, data_sram_rdata);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_apend = 0; m_rpend = 0; m_drop = 0; m_held = 0; m_cap = '0;
    end else if (m_held) begin
      if (ws_allowin || flush) m_held = 0;
    end else if (m_apend) begin
      if (data_sram_addr_ok) begin
        m_apend = 0; m_rpend = 1; m_drop = flush;
      end else if (flush) m_apend = 0;
    end else if (m_rpend) begin
      if (data_sram_data_ok) begin
        m_rpend = 0;
        if (!m_drop && !flush && BUF) begin
          m_held = 1; m_held_ld = !ms_we; m_cap = data_sram_rdata;
        end
      end else if (flush) m_drop = 1;
    end else if (m_iss) begin
      if (data_sram_addr_ok) begin m_rpend = 1; m_drop = 0; end
      else m_apend = 1;
    end
    #1;
  endtask

  task automatic set_instr(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb, input logic ex);
    ms_valid = 1; ms_mem_req = 1; ms_we = we; ms_size = size;
    ms_addr = addr; ms_wdata = wdata; ms_wstrb = wstrb; ms_ex = ex;
  endtask

  initial begin
    int hs;
    rst = 1; flush = 0; ws_allowin = 1;
    data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = '0;
    set_instr(0, 2'd2, 32'h1C00_0000, '0, 4'hF, 0);
    m_apend = 0; m_rpend = 0; m_drop = 0; m_held = 0; m_held_ld = 0; m_cap = '0; m_iss = 0;
    #1;

    // reset state, with a pending load presented on the inputs
    sample(); chk1("rst_req", data_sram_req, 1'b0); chk1("rst_rg", mem_ready_go, 1'b0); advance();
    sample(); advance();
    rst = 0; ms_valid = 0;
    sample(); chk1("idle_req", data_sram_req, 1'b0); chk32("idle_rdata", mem_dram_rdata, 32'd0); advance();

    // word load, addr_ok in issue cycle, data_ok next cycle
    set_instr(0, 2'd2, 32'h1C00_0100, '0, 4'hF, 0);
    data_sram_addr_ok = 1;
    sample(); chk1("t026_issue", data_sram_req, 1'b1); advance();
    data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hDEAD_BEEF;
    sample();
    if (!BUF) begin
      chk1("t026_rg", mem_ready_go, 1'b1); chk32("t026_rdata", mem_dram_rdata, 32'hDEAD_BEEF);
    end
    advance();
    data_sram_data_ok = 0; data_sram_rdata = '0;
    if (BUF) begin
      sample(); chk1("t026_rg", mem_ready_go, 1'b1); chk32("t026_rdata", mem_dram_rdata, 32'hDEAD_BEEF);
      advance();
    end
    ms_valid = 0;
    sample(); chk1("t026_after", mem_ready_go, 1'b0); advance();

    // byte store with addr_ok delayed three cycles
    set_instr(1, 2'd0, 32'h1C00_0201, 32'h0000_AB00, 4'h2, 0);
    hs = 0;
    for (int i = 0; i < 4; i++) begin
      data_sram_addr_ok = (i == 3);
      sample();
      chk1("t027_req", data_sram_req, 1'b1);
      chk32("t027_addr", data_sram_addr, 32'h1C00_0201);
      chk1("t027_wr", data_sram_wr, 1'b1);
      chk32("t027_wstrb", 32'(data_sram_wstrb), 32'h2);
      if (data_sram_req && data_sram_addr_ok) hs++;
      advance();
    end
    data_sram_addr_ok = 0; data_sram_data_ok = 1;
    sample(); chk1("t027_noreq", data_sram_req, 1'b0);
    if (data_sram_req && data_sram_addr_ok) hs++;
    advance();
    data_sram_data_ok = 0;
    if (BUF) begin sample(); chk1("t027_rg", mem_ready_go, 1'b1); advance(); end
    ms_valid = 0;
    sample(); advance();
    chk32("t027_handshakes", hs, 32'd1);

    // load accepted, flushed in WAIT, response two cycles later
    set_instr(0, 2'd2, 32'h1C00_0300, '0, 4'hF, 0);
    data_sram_addr_ok = 1;
    sample(); advance();
    data_sram_addr_ok = 0; flush = 1;
    sample(); chk1("t028_rg_flush", mem_ready_go, 1'b0); advance();
    flush = 0; ms_valid = 0;
    sample(); chk1("t028_rg_gap", mem_ready_go, 1'b0); advance();
    data_sram_data_ok = 1; data_sram_rdata = 32'h1234_5678;
    sample(); chk1("t028_rg_drop", mem_ready_go, 1'b0); advance();
    data_sram_data_ok = 0;
    set_instr(0, 2'd2, 32'h1C00_0304, '0, 4'hF, 0);
    sample(); chk1("t028_idle_again", data_sram_req, 1'b1); advance();
    flush = 1;
    sample(); advance();
    flush = 0; ms_valid = 0;
    sample(); advance();

    // load carrying an exception
    set_instr(0, 2'd2, 32'h1C00_0400, '0, 4'hF, 1);
    data_sram_addr_ok = 1;
    sample(); chk1("t029_req", data_sram_req, 1'b0); chk1("t029_rg", mem_ready_go, 1'b1); advance();
    data_sram_addr_ok = 0; ms_ex = 0; ms_valid = 0;

    // load completes while WB stalls
    set_instr(0, 2'd2, 32'h1C00_0500, '0, 4'hF, 0);
    data_sram_addr_ok = 1;
    sample(); advance();
    data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hCAFE_F00D; ws_allowin = 0;
    sample(); advance();
    data_sram_data_ok = 0; data_sram_rdata = '0;
    if (BUF) begin
      for (int i = 0; i < 3; i++) begin
        sample(); chk1("t030_hold_rg", mem_ready_go, 1'b1);
        chk32("t030_hold_rdata", mem_dram_rdata, 32'hCAFE_F00D); advance();
      end
      ws_allowin = 1;
      sample(); chk1("t030_release", mem_ready_go, 1'b1); advance();
    end else begin
      ms_valid = 0;
      sample(); chk1("t030_ignored", mem_ready_go, 1'b0); advance();
    end
    ws_allowin = 1; ms_valid = 0;
    sample(); chk1("t030_after", mem_ready_go, 1'b0); advance();

    // reset while waiting for the response
    set_instr(0, 2'd2, 32'h1C00_0600, '0, 4'hF, 0);
    data_sram_addr_ok = 1;
    sample(); advance();
    data_sram_addr_ok = 0; rst = 1;
    sample(); advance();
    rst = 0; ms_valid = 0;
    sample();
    chk1("t031_req", data_sram_req, 1'b0); chk1("t031_rg", mem_ready_go, 1'b0);
    chk32("t031_rdata", mem_dram_rdata, 32'd0);
    advance();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (!(m_apend || m_rpend || m_held)) begin
        ms_valid   = ($urandom % 4) != 0;
        ms_mem_req = ($urandom % 4) != 0;
        ms_we      = ($urandom % 2) != 0;
        ms_ex      = ($urandom % 8) == 0;
        ms_size    = 2'($urandom_range(2));
        ms_addr    = $urandom;
        ms_wdata   = $urandom;
        ms_wstrb   = 4'($urandom);
      end
      data_sram_addr_ok = ($urandom % 3) == 0;
      data_sram_data_ok = m_rpend && (($urandom % 3) == 0);
      data_sram_rdata   = $urandom;
      flush             = ($urandom % 10) == 0;
      ws_allowin        = ($urandom % 2) != 0;
      rst               = ($urandom % 200) == 0;
      sample();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
